snake_game_ctrl: RTL and testbench

// Game sequencer for the snake head renderer. Synchronises and debounces the

---
 rtl/snake_game_ctrl_if.sv | 32 +++
 rtl/snake_game_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/snake_game_ctrl_if.sv
// Player/datapath handshake bundle for the snake game sequencer.
// Latency: none, pure wiring.
// Backpressure: none; all signals are level or single-cycle pulse.
interface snake_game_ctrl_if #(
  parameter int BIT = 10
);
  logic           btn_up;
  logic           btn_down;
  logic           btn_left;
  logic           btn_right;
  logic           btn_start;
  logic           frame_tick;
  logic [BIT-1:0] head_x;
  logic [BIT-1:0] head_y;
  logic [2:0]     direction;
  logic [1:0]     game_state;
  logic [7:0]     score;

  // Environment side: buttons, frame timing and head position in, game outputs back.
  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_start,
    output frame_tick, head_x, head_y,
    input  direction, game_state, score
  );

  // Controller side.
  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_start,
    input  frame_tick, head_x, head_y,
    output direction, game_state, score
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: button sync/debounce, START/PLAY/PAUSE/GAME_OVER FSM, wall collision, score.
// Latency: outputs registered, 1 clk after tick/press; button press pulse ~DB_CYCLES+2 clks after input settles.
// Backpressure: none; frame_tick and button presses are consumed the cycle they occur.
module snake_game_ctrl #(
  parameter int BIT       = 10,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int SIZE      = 25,
  parameter int SPEED     = 35,
  parameter int DB_CYCLES = 250000,
  parameter int GO_FRAMES = 120
) (
  input  logic             clk,
  input  logic             reset,
  snake_game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_START     = 2'b00,
    ST_PLAY      = 2'b01,
    ST_PAUSE     = 2'b10,
    ST_GAME_OVER = 2'b11
  } state_t;

  typedef enum logic [2:0] {
    DIR_IDLE  = 3'b000,
    DIR_UP    = 3'b001,
    DIR_DOWN  = 3'b010,
    DIR_LEFT  = 3'b011,
    DIR_RIGHT = 3'b100
  } dir_t;

  localparam int W  = BIT + 1;
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int GW = $clog2(GO_FRAMES + 1);

  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] DB_ONE  = CW'(1);
  localparam logic [GW-1:0] GO_LAST = GW'(GO_FRAMES - 1);
  localparam logic [GW-1:0] GO_ONE  = GW'(1);
  localparam logic [W-1:0]  SPD     = W'(SPEED);
  localparam logic [W-1:0]  SZ      = W'(SIZE);
  localparam logic [W-1:0]  HR      = W'(H_RES);
  localparam logic [W-1:0]  VR      = W'(V_RES);

  // Button bit order: {start, right, left, down, up}
  localparam int B_UP    = 0;
  localparam int B_DOWN  = 1;
  localparam int B_LEFT  = 2;
  localparam int B_RIGHT = 3;
  localparam int B_START = 4;

  logic [4:0]    btn_raw;
  logic [4:0]    sync1, sync2, db_lvl, press;
  logic [CW-1:0] db_cnt [5];

  state_t        st_q, st_n;
  dir_t          dir_q, dir_n, pend_q, pend_n, saved_q, saved_n;
  logic [7:0]    score_q, score_n;
  logic [GW-1:0] go_q, go_n;

  dir_t          req_dir, commit_dir;
  logic          req_vld, accept, collide;
  logic [W-1:0]  hx, hy;

  assign btn_raw = {bus.btn_start, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
  assign hx      = {1'b0, bus.head_x};
  assign hy      = {1'b0, bus.head_y};

  function automatic dir_t reverse_of(input dir_t d);
    case (d)
      DIR_UP:    reverse_of = DIR_DOWN;
      DIR_DOWN:  reverse_of = DIR_UP;
      DIR_LEFT:  reverse_of = DIR_RIGHT;
      DIR_RIGHT: reverse_of = DIR_LEFT;
      default:   reverse_of = DIR_IDLE;
    endcase
  endfunction

  // Two-flop synchronisers, per-button debounce counters and debounced rising-edge press pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      db_lvl <= '0;
      press  <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 5; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] != db_lvl[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db_lvl[i] <= sync2[i];
            db_cnt[i] <= '0;
            press[i]  <= sync2[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_ONE;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Direction request: fixed priority UP > DOWN > LEFT > RIGHT; reverse of committed direction is refused.
  always_comb begin
    req_vld = 1'b1;
    req_dir = DIR_IDLE;
    if (press[B_UP])         req_dir = DIR_UP;
    else if (press[B_DOWN])  req_dir = DIR_DOWN;
    else if (press[B_LEFT])  req_dir = DIR_LEFT;
    else if (press[B_RIGHT]) req_dir = DIR_RIGHT;
    else                     req_vld = 1'b0;
    accept     = req_vld && (req_dir != reverse_of(dir_q));
    commit_dir = accept ? req_dir : pend_q;
  end

  // Wall check for the direction about to be committed; one extra bit so sums never wrap.
  always_comb begin
    collide = 1'b0;
    case (commit_dir)
      DIR_UP:    collide = hy < SPD;
      DIR_DOWN:  collide = (hy + SPD + SZ) > VR;
      DIR_LEFT:  collide = hx < SPD;
      DIR_RIGHT: collide = (hx + SPD + SZ) > HR;
      default:   collide = 1'b0;
    endcase
  end

  // Game state register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= ST_START;
      dir_q   <= DIR_IDLE;
      pend_q  <= DIR_IDLE;
      saved_q <= DIR_IDLE;
      score_q <= '0;
      go_q    <= '0;
    end else begin
      st_q    <= st_n;
      dir_q   <= dir_n;
      pend_q  <= pend_n;
      saved_q <= saved_n;
      score_q <= score_n;
      go_q    <= go_n;
    end
  end

  // Next-state logic; a tick in PLAY is fully processed before a same-cycle pause request.
  always_comb begin
    st_n    = st_q;
    dir_n   = dir_q;
    pend_n  = pend_q;
    saved_n = saved_q;
    score_n = score_q;
    go_n    = go_q;
    case (st_q)
      ST_START: begin
        dir_n = DIR_IDLE;
        if (press[B_START]) begin
          st_n    = ST_PLAY;
          score_n = '0;
          pend_n  = DIR_IDLE;
          go_n    = '0;
        end
      end
      ST_PLAY: begin
        if (accept) pend_n = req_dir;
        if (bus.frame_tick) begin
          if (collide) begin
            st_n  = ST_GAME_OVER;
            dir_n = DIR_IDLE;
            go_n  = '0;
          end else begin
            dir_n  = commit_dir;
            pend_n = commit_dir;
            if (commit_dir != DIR_IDLE && score_q != 8'hFF) score_n = score_q + 8'd1;
          end
        end
        if (press[B_START] && !(bus.frame_tick && collide)) begin
          st_n    = ST_PAUSE;
          saved_n = bus.frame_tick ? commit_dir : dir_q;
          dir_n   = DIR_IDLE;
        end
      end
      ST_PAUSE: begin
        if (press[B_START]) begin
          st_n   = ST_PLAY;
          dir_n  = saved_q;
          pend_n = saved_q;
        end
      end
      default: begin
        dir_n = DIR_IDLE;
        if (bus.frame_tick) begin
          if (go_q == GO_LAST) begin
            st_n = ST_START;
            go_n = '0;
          end else begin
            go_n = go_q + GO_ONE;
          end
        end
      end
    endcase
  end

  assign bus.direction  = dir_q;
  assign bus.game_state = st_q;
  assign bus.score      = score_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with short debounce and game-over timing.
module tb_snake_game_ctrl;

  typedef struct {
    string      name;
    logic [4:0] btn;   // {start, right, left, down, up}
    logic       tick;
    logic [9:0] hx;
    logic [9:0] hy;
    int         cyc;
    logic [1:0] st;
    logic [2:0] dir;
    logic [7:0] sc;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[$];

  snake_game_ctrl_if #(.BIT(10)) sif ();

  snake_game_ctrl #(
    .BIT(10), .H_RES(640), .V_RES(480), .SIZE(25), .SPEED(35),
    .DB_CYCLES(4), .GO_FRAMES(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (sif)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no end, want summary");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic add(input string n, input logic [4:0] b, input logic t,
                     input logic [9:0] x, input logic [9:0] y, input int c,
                     input logic [1:0] s, input logic [2:0] d, input logic [7:0] sc);
    vec_t v;
    v.name = n; v.btn = b; v.tick = t; v.hx = x; v.hy = y; v.cyc = c;
    v.st = s; v.dir = d; v.sc = sc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [4:0] b, input logic t, input logic [9:0] x, input logic [9:0] y);
    sif.btn_up    = b[0];
    sif.btn_down  = b[1];
    sif.btn_left  = b[2];
    sif.btn_right = b[3];
    sif.btn_start = b[4];
    sif.frame_tick = t;
    sif.head_x    = x;
    sif.head_y    = y;
  endtask

  task automatic check(input string n, input logic [1:0] s, input logic [2:0] d, input logic [7:0] sc);
    tests++;
    if (sif.game_state !== s) begin
      fails++;
      $display("FAIL %s game_state: got %b want %b", n, sif.game_state, s);
    end
    tests++;
    if (sif.direction !== d) begin
      fails++;
      $display("FAIL %s direction: got %b want %b", n, sif.direction, d);
    end
    tests++;
    if (sif.score !== sc) begin
      fails++;
      $display("FAIL %s score: got %0d want %0d", n, sif.score, sc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Hold start until its press pulse is one clk away, then put a frame tick on that same clk.
  task automatic start_with_tick(input logic [9:0] y);
    drive(5'b10000, 1'b0, 10'd300, y);
    repeat (6) @(posedge clk);
    @(negedge clk);
    sif.frame_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sif.frame_tick = 1'b0;
  endtask

  task automatic one_tick(input logic [9:0] y);
    drive(5'b00000, 1'b1, 10'd300, y);
    @(posedge clk);
    @(negedge clk);
    sif.frame_tick = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [4:0] B0 = 5'b00000, BS = 5'b10000, BR = 5'b01000,
                         BL = 5'b00100, BD = 5'b00010, BU = 5'b00001;

  initial begin
    // name, btn, tick, hx, hy, cycles, expected state, direction, score
    add("reset_state",       B0, 0, 300, 200, 1, 2'b00, 3'b000, 0);
    add("start_press",       BS, 0, 300, 200, 7, 2'b01, 3'b000, 0);
    add("start_release",     B0, 0, 300, 200, 8, 2'b01, 3'b000, 0);
    add("right_press",       BR, 0, 300, 200, 7, 2'b01, 3'b000, 0);
    add("right_release",     B0, 0, 300, 200, 8, 2'b01, 3'b000, 0);
    add("tick_right",        B0, 1, 300, 200, 1, 2'b01, 3'b100, 1);
    add("up_glitch",         BU, 0, 300, 200, 2, 2'b01, 3'b100, 1);
    add("glitch_settle",     B0, 0, 300, 200, 8, 2'b01, 3'b100, 1);
    add("tick_after_glitch", B0, 1, 300, 200, 1, 2'b01, 3'b100, 2);
    add("left_press",        BL, 0, 300, 200, 7, 2'b01, 3'b100, 2);
    add("left_release",      B0, 0, 300, 200, 8, 2'b01, 3'b100, 2);
    add("tick_reverse_ign",  B0, 1, 300, 200, 1, 2'b01, 3'b100, 3);
    add("updown_press",      BU|BD, 0, 300, 200, 7, 2'b01, 3'b100, 3);
    add("updown_release",    B0, 0, 300, 200, 8, 2'b01, 3'b100, 3);
    add("tick_up_priority",  B0, 1, 300, 200, 1, 2'b01, 3'b001, 4);
    add("left2_press",       BL, 0, 300, 200, 7, 2'b01, 3'b001, 4);
    add("left2_release",     B0, 0, 300, 200, 8, 2'b01, 3'b001, 4);
    add("tick_left",         B0, 1, 300, 200, 1, 2'b01, 3'b011, 5);
    add("left_wall",         B0, 1,  30, 200, 1, 2'b11, 3'b000, 5);
    add("go_tick1",          B0, 1,  30, 200, 1, 2'b11, 3'b000, 5);
    add("go_start_ignored",  BS, 0, 300, 200, 7, 2'b11, 3'b000, 5);
    add("go_start_release",  B0, 0, 300, 200, 8, 2'b11, 3'b000, 5);
    add("go_tick2",          B0, 1, 300, 200, 1, 2'b11, 3'b000, 5);
    add("go_tick3_to_start", B0, 1, 300, 200, 1, 2'b00, 3'b000, 5);
    add("start2_press",      BS, 0, 300, 200, 7, 2'b01, 3'b000, 0);
    add("start2_release",    B0, 0, 300, 200, 8, 2'b01, 3'b000, 0);
    add("down_press",        BD, 0, 300, 200, 7, 2'b01, 3'b000, 0);
    add("down_release",      B0, 0, 300, 200, 8, 2'b01, 3'b000, 0);
    add("down_edge_480_ok",  B0, 1, 300, 420, 1, 2'b01, 3'b010, 1);
    add("down_wall_481",     B0, 1, 300, 421, 1, 2'b11, 3'b000, 1);
    add("go2_tick1",         B0, 1, 300, 200, 1, 2'b11, 3'b000, 1);
    add("go2_tick2",         B0, 1, 300, 200, 1, 2'b11, 3'b000, 1);
    add("go2_tick3",         B0, 1, 300, 200, 1, 2'b00, 3'b000, 1);
    add("start3_press",      BS, 0, 300, 200, 7, 2'b01, 3'b000, 0);
    add("start3_release",    B0, 0, 300, 200, 8, 2'b01, 3'b000, 0);
    add("right3_press",      BR, 0, 300, 200, 7, 2'b01, 3'b000, 0);
    add("right3_release",    B0, 0, 300, 200, 8, 2'b01, 3'b000, 0);
    add("right_edge_640_ok", B0, 1, 580, 200, 1, 2'b01, 3'b100, 1);
    add("right_wall_641",    B0, 1, 581, 200, 1, 2'b11, 3'b000, 1);
    add("go3_tick1",         B0, 1, 300, 200, 1, 2'b11, 3'b000, 1);
    add("go3_tick2",         B0, 1, 300, 200, 1, 2'b11, 3'b000, 1);
    add("go3_tick3",         B0, 1, 300, 200, 1, 2'b00, 3'b000, 1);
    add("start4_press",      BS, 0, 300, 200, 7, 2'b01, 3'b000, 0);
    add("start4_release",    B0, 0, 300, 200, 8, 2'b01, 3'b000, 0);
    add("up_press",          BU, 0, 300, 200, 7, 2'b01, 3'b000, 0);
    add("up_release",        B0, 0, 300, 200, 8, 2'b01, 3'b000, 0);
    add("up_edge_y35_ok",    B0, 1, 300,  35, 1, 2'b01, 3'b001, 1);
    add("pause_press",       BS, 0, 300, 200, 7, 2'b10, 3'b000, 1);
    add("pause_release",     B0, 0, 300, 200, 8, 2'b10, 3'b000, 1);
    add("pause_tick_ign",    B0, 1, 300, 200, 1, 2'b10, 3'b000, 1);
    add("pause_down_press",  BD, 0, 300, 200, 7, 2'b10, 3'b000, 1);
    add("pause_down_rel",    B0, 0, 300, 200, 8, 2'b10, 3'b000, 1);
    add("resume_press",      BS, 0, 300, 200, 7, 2'b01, 3'b001, 1);
    add("resume_release",    B0, 0, 300, 200, 8, 2'b01, 3'b001, 1);
    add("tick_after_resume", B0, 1, 300, 200, 1, 2'b01, 3'b001, 2);

    drive(B0, 1'b0, 10'd300, 10'd200);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_reset", 2'b00, 3'b000, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].btn, vecs[i].tick, vecs[i].hx, vecs[i].hy);
      cycles(vecs[i].cyc);
      check(vecs[i].name, vecs[i].st, vecs[i].dir, vecs[i].sc);
    end

    // Start press and frame tick on the same clk, no collision: tick counted, then pause.
    start_with_tick(10'd200);
    check("start_tick_pause", 2'b10, 3'b000, 3);
    drive(B0, 1'b0, 10'd300, 10'd200);
    cycles(8);
    drive(BS, 1'b0, 10'd300, 10'd200);
    cycles(7);
    check("resume_after_start_tick", 2'b01, 3'b001, 3);
    drive(B0, 1'b0, 10'd300, 10'd200);
    cycles(8);

    // Score saturation.
    for (int k = 0; k < 251; k++) one_tick(10'd200);
    check("score_254", 2'b01, 3'b001, 254);
    one_tick(10'd200);
    check("score_255", 2'b01, 3'b001, 255);
    for (int k = 0; k < 3; k++) one_tick(10'd200);
    check("score_saturated", 2'b01, 3'b001, 255);

    // Start press and colliding tick on the same clk: game over wins over pause.
    start_with_tick(10'd10);
    check("start_tick_collide", 2'b11, 3'b000, 255);
    drive(B0, 1'b0, 10'd300, 10'd200);

    // Reset while in game over returns everything to the reset state next clk.
    reset = 1'b1;
    cycles(1);
    check("reset_mid_game", 2'b00, 3'b000, 0);
    reset = 1'b0;
    cycles(2);
    check("after_reset_idle", 2'b00, 3'b000, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
